alarm_text_ctrl: RTL and testbench
==================================

Name: alarm_text_ctrl

Overview:
- Sequences the 128x16 "ALARM" text overlay for the VGA alarm clock.
- Compares the running clock time against the alarm setting and runs the arm / ring / snooze state machine.
- Drives the overlay's top-left position and visibility, blinks the text while ringing, and gates the overlay's pixel output into the pixel mux.
- Sits between the timekeeping counters, the debounced buttons, the VGA sync block and the text overlay.

Parameters:
- TEXT_X, 256, fixed top-left x of the overlay (pixels)
- TEXT_Y, 32, fixed top-left y of the overlay (pixels)
- BLINK_FRAMES, 30, frames per blink half-period while ringing
- RING_FRAMES, 1800, frames of ringing before auto-timeout
- SNOOZE_SEC, 300, snooze duration in seconds
- H_LIMIT, 512, maximum x for the overlay left edge (640-128)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- sec_tick  in  1  one-cycle pulse per second from timekeeping
- cur_hh  in  5  current hour, binary 0-23
- cur_mm  in  6  current minute, binary 0-59
- cur_ss  in  6  current second, binary 0-59
- alm_hh  in  5  alarm hour, binary
- alm_mm  in  6  alarm minute, binary
- alarm_en  in  1  alarm enable switch (level)
- snooze_btn  in  1  debounced one-cycle pulse
- stop_btn  in  1  debounced one-cycle pulse
- text_pixel_on  in  1  "on" output of the text overlay
- text_x  out  10  overlay top-left x
- text_y  out  10  overlay top-left y
- overlay_on  out  1  gated pixel enable to the pixel mux
- buzzer  out  1  high while ringing
- state_dbg  out  2  encoded FSM state

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Reset values: state IDLE, text_x=TEXT_X, text_y=TEXT_Y, text_show=0, buzzer=0, all counters 0, blink phase 1.
- All outputs except overlay_on are registered.
- overlay_on = text_pixel_on & text_show, combinational with no added latency.
- FSM encoding: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- IDLE: text_show=0. If alarm_en=1, go to ARMED next cycle.
- ARMED: text_show=1 (steady).
  - Match = (cur_hh==alm_hh) && (cur_mm==alm_mm) && (cur_ss==0) && sec_tick.
  - On match: go to RINGING, clear the ring counter, set blink phase to 1, clear the blink counter.
  - Match fires once per minute only.
- RINGING: buzzer=1, text_show = blink phase.
  - On each frame_tick: blink counter increments. At BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - On each frame_tick: ring counter increments. At RING_FRAMES-1 the FSM returns to ARMED.
  - stop_btn: go to ARMED.
  - snooze_btn: go to SNOOZE, load the snooze counter with SNOOZE_SEC.
  - Match conditions while in RINGING are ignored.
- SNOOZE: buzzer=0, text_show=1 (steady).
  - Each sec_tick decrements the snooze counter.
  - Count 1 and sec_tick: go to RINGING, with counters and phase reinitialised as on a match.
  - stop_btn: go to ARMED.
  - snooze_btn: reloads SNOOZE_SEC.
- Priority within a cycle: alarm_en=0 (to IDLE from any state, buzzer drops the same edge) > stop_btn > snooze_btn > timeout/match/countdown.
- text_show and position are updated only on frame_tick cycles; state changes take visual effect at the next frame_tick.
  - Exception: alarm_en=0 and reset clear text_show immediately.
- Counter widths: blink 5b, ring 11b, snooze 9b. Comparisons are unsigned. No counter may wrap past its terminal value.

Optional Feature:
- Macro: ALARM_BOUNCE_EN.
- Defined:
  - While RINGING, text_x moves 1 pixel per frame_tick; direction register resets to +1.
  - At text_x==H_LIMIT the direction becomes -1; at text_x==0 it becomes +1. The reversal step occurs on the same frame, so the edge value is held for exactly one frame.
  - On leaving RINGING, text_x returns to TEXT_X on the next frame_tick.
  - text_y stays TEXT_Y.
- Undefined: text_x is constant TEXT_X and no direction register exists.

Test Plan:
- Arm and match: reset_n=0 for 2 cycles, then alarm_en=1, alm=07:30, cur steps 07:29:59 -> 07:30:00 with sec_tick. Required: state_dbg 0->1, then 2 the cycle after the tick; buzzer=1.
- Blink timing: in RINGING, issue 60 frame_ticks. Required: text_show=1 for ticks 1-30, 0 for ticks 31-60; overlay_on follows text_pixel_on only while text_show=1.
- Snooze: snooze_btn in RINGING with SNOOZE_SEC=3 override. Required: state 3, buzzer 0. After 3 sec_ticks: state 2, phase 1.
- Priority: snooze_btn and stop_btn in the same cycle. Required: state 1, buzzer 0. alarm_en drop mid-RINGING: state 0, text_show 0 on the next edge.
- Timeout: RING_FRAMES=10 override; 10 frame_ticks with no buttons. Required: state 1; no retrigger while cur_ss stays at 00.
- Bounce (ALARM_BOUNCE_EN, TEXT_X=510): frame_ticks in RINGING. Required: text_x 511, 512, 512, 511, ...; after stop_btn, text_x returns to 510 at the next frame_tick.

Source files
------------

// File: rtl/alarm_text_ctrl.sv
// Alarm arm/ring/snooze sequencer driving placement, blink and gating of the 128x16 ALARM text overlay.
// Build option ALARM_BOUNCE_EN: the text bounces horizontally while ringing.
module alarm_text_ctrl #(
  parameter int TEXT_X       = 256,
  parameter int TEXT_Y       = 32,
  parameter int BLINK_FRAMES = 30,
  parameter int RING_FRAMES  = 1800,
  parameter int SNOOZE_SEC   = 300,
  parameter int H_LIMIT      = 512
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       sec_tick,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [5:0] cur_ss,
  input  logic [4:0] alm_hh,
  input  logic [5:0] alm_mm,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  input  logic       text_pixel_on,
  output logic [9:0] text_x,
  output logic [9:0] text_y,
  output logic       overlay_on,
  output logic       buzzer,
  output logic [1:0] state_dbg
);

  // state   | meaning
  // IDLE    | alarm disabled, text hidden
  // ARMED   | waiting for hh:mm:00, text steady
  // RINGING | buzzer on, text blinking
  // SNOOZE  | buzzer off, counting seconds back to RINGING
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  // The left edge can never sit past H_LIMIT, so the home position is clamped to it.
  localparam int        TX_HOME     = (TEXT_X > H_LIMIT) ? H_LIMIT : TEXT_X;
  localparam logic [9:0] X_HOME     = 10'(TX_HOME);
  localparam logic [9:0] Y_HOME     = 10'(TEXT_Y);
  localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);
  localparam logic [10:0] RING_LAST = 11'(RING_FRAMES - 1);
  localparam logic [8:0] SNZ_LOAD   = 9'(SNOOZE_SEC);

  state_t      state_q, state_d;
  logic [4:0]  blink_q, blink_d;
  logic [10:0] ring_q, ring_d;
  logic [8:0]  snz_q, snz_d;
  logic        phase_q, phase_d;
  logic        show_q, show_d;
  logic        lock_q, lock_d;
  logic        buzz_q, buzz_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q;
  logic        match;
  logic        start_ring;

  assign match = (cur_hh == alm_hh) && (cur_mm == alm_mm) && (cur_ss == 6'd0) && sec_tick;

  always_comb begin
    state_d    = state_q;
    blink_d    = blink_q;
    ring_d     = ring_q;
    snz_d      = snz_q;
    phase_d    = phase_q;
    show_d     = show_q;
    lock_d     = lock_q;
    start_ring = 1'b0;

    // A match can only re-fire once the seconds have moved off :00.
    if (cur_ss != 6'd0) lock_d = 1'b0;

    if (frame_tick) begin
      case (state_q)
        IDLE:    show_d = 1'b0;
        RINGING: show_d = phase_q;
        default: show_d = 1'b1;
      endcase
    end

    if (!alarm_en) begin
      state_d = IDLE;
      show_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match && !lock_q) begin
            start_ring = 1'b1;
            lock_d     = 1'b1;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state_d = ARMED;
          end else if (snooze_btn) begin
            state_d = SNOOZE;
            snz_d   = SNZ_LOAD;
          end else if (frame_tick) begin
            if (blink_q >= BLINK_LAST) begin
              blink_d = 5'd0;
              phase_d = ~phase_q;
            end else begin
              blink_d = blink_q + 5'd1;
            end
            if (ring_q >= RING_LAST) begin
              state_d = ARMED;
              ring_d  = 11'd0;
            end else begin
              ring_d = ring_q + 11'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_d = ARMED;
          end else if (snooze_btn) begin
            snz_d = SNZ_LOAD;
          end else if (sec_tick) begin
            if (snz_q <= 9'd1) start_ring = 1'b1;
            else               snz_d      = snz_q - 9'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_ring) begin
      state_d = RINGING;
      ring_d  = 11'd0;
      blink_d = 5'd0;
      phase_d = 1'b1;
    end

    buzz_d = (state_d == RINGING);
  end

`ifdef ALARM_BOUNCE_EN
  logic dir_q, dir_d;  // 1 = moving left

  always_comb begin
    x_d   = x_q;
    dir_d = dir_q;
    if (frame_tick) begin
      if (state_q == RINGING) begin
        if (!dir_q && (x_q >= 10'(H_LIMIT))) begin
          dir_d = 1'b1;
        end else if (dir_q && (x_q == 10'd0)) begin
          dir_d = 1'b0;
        end else begin
          x_d = dir_q ? (x_q - 10'd1) : (x_q + 10'd1);
        end
      end else begin
        x_d = X_HOME;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) dir_q <= 1'b0;
    else          dir_q <= dir_d;
  end
`else
  assign x_d = X_HOME;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      blink_q <= 5'd0;
      ring_q  <= 11'd0;
      snz_q   <= 9'd0;
      phase_q <= 1'b1;
      show_q  <= 1'b0;
      lock_q  <= 1'b0;
      buzz_q  <= 1'b0;
      x_q     <= X_HOME;
      y_q     <= Y_HOME;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      phase_q <= phase_d;
      show_q  <= show_d;
      lock_q  <= lock_d;
      buzz_q  <= buzz_d;
      x_q     <= x_d;
      y_q     <= Y_HOME;
    end
  end

  assign text_x     = x_q;
  assign text_y     = y_q;
  assign buzzer     = buzz_q;
  assign state_dbg  = state_q;
  assign overlay_on = text_pixel_on & show_q;

endmodule

// File: tb/tb_alarm_text_ctrl.sv
// Directed plus randomized bench for alarm_text_ctrl against a cycle-level behavioural model.
// Build with ALARM_BOUNCE_EN defined to exercise the bouncing-text variant.
module tb_alarm_text_ctrl;
  localparam int TX = 510;
  localparam int TY = 32;
  localparam int BF = 30;
  localparam int RF = 70;
  localparam int SS = 3;
  localparam int HL = 512;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0, sec_tick = 1'b0;
  logic [4:0] cur_hh = '0, alm_hh = '0;
  logic [5:0] cur_mm = '0, cur_ss = '0, alm_mm = '0;
  logic       alarm_en = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0, text_pixel_on = 1'b0;
  logic [9:0] text_x, text_y;
  logic       overlay_on, buzzer;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;

  // behavioural model state
  int m_st, m_blink, m_ring, m_snz, m_phase, m_show, m_lock, m_x, m_dir;

  alarm_text_ctrl #(
    .TEXT_X(TX), .TEXT_Y(TY), .BLINK_FRAMES(BF), .RING_FRAMES(RF), .SNOOZE_SEC(SS), .H_LIMIT(HL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .sec_tick(sec_tick),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss), .alm_hh(alm_hh), .alm_mm(alm_mm),
    .alarm_en(alarm_en), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .text_pixel_on(text_pixel_on), .text_x(text_x), .text_y(text_y),
    .overlay_on(overlay_on), .buzzer(buzzer), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_blink = 0; m_ring = 0; m_snz = 0; m_phase = 1;
    m_show = 0; m_lock = 0; m_x = TX; m_dir = 1;
  endtask

  task automatic model_begin_ring(output int ns);
    ns = M_RING; m_ring = 0; m_blink = 0; m_phase = 1;
  endtask

  // One clock of the alarm rules, evaluated on the inputs present before the edge.
  task automatic model_step();
    bit match, old_lock;
    int ns;
    if (!reset_n) begin
      model_reset();
      return;
    end
    match = (cur_hh == alm_hh) && (cur_mm == alm_mm) && (cur_ss == 0) && sec_tick;
    old_lock = (m_lock != 0);
    if (cur_ss != 0) m_lock = 0;
    ns = m_st;
    if (frame_tick) begin
`ifdef ALARM_BOUNCE_EN
      if (m_st == M_RING) begin
        if (m_dir > 0 && m_x == HL) m_dir = -1;
        else if (m_dir < 0 && m_x == 0) m_dir = 1;
        else m_x = m_x + m_dir;
      end else begin
        m_x = TX;
      end
`endif
      m_show = (m_st == M_IDLE) ? 0 : (m_st == M_RING) ? m_phase : 1;
    end
    if (!alarm_en) begin
      ns = M_IDLE;
      m_show = 0;
    end else begin
      case (m_st)
        M_IDLE: ns = M_ARMED;
        M_ARMED: if (match && !old_lock) begin
          model_begin_ring(ns);
          m_lock = 1;
        end
        M_RING: begin
          if (stop_btn) ns = M_ARMED;
          else if (snooze_btn) begin ns = M_SNZ; m_snz = SS; end
          else if (frame_tick) begin
            m_blink++;
            if (m_blink == BF) begin m_blink = 0; m_phase = 1 - m_phase; end
            m_ring++;
            if (m_ring == RF) begin m_ring = 0; ns = M_ARMED; end
          end
        end
        default: begin
          if (stop_btn) ns = M_ARMED;
          else if (snooze_btn) m_snz = SS;
          else if (sec_tick) begin
            if (m_snz <= 1) model_begin_ring(ns);
            else m_snz--;
          end
        end
      endcase
    end
    m_st = ns;
  endtask

  // Advance one clock, compare every output with the model, then drop one-cycle pulses.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("state", 32'(state_dbg), 32'(m_st));
    check("buzzer", 32'(buzzer), 32'(m_st == M_RING));
    check("text_x", 32'(text_x), 32'(m_x));
    check("text_y", 32'(text_y), 32'(TY));
    frame_tick = 1'b0; sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    #1;
    check("overlay", 32'(overlay_on), 32'(text_pixel_on & (m_show != 0)));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      text_pixel_on = 1'($urandom_range(0, 1));
      cyc();
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hh = 5'(h); cur_mm = 6'(m); cur_ss = 6'(s);
  endtask

  initial begin
    int xs[6];
    model_reset();

    // reset and arming
    reset_n = 1'b0;
    gap(2);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_text_x", 32'(text_x), 32'(TX));
    check("rst_buzzer", 32'(buzzer), 32'd0);
    reset_n = 1'b1; alarm_en = 1'b1;
    alm_hh = 5'd7; alm_mm = 6'd30; set_cur(7, 29, 59);
    cyc();
    check("armed", 32'(state_dbg), 32'd1);
    frame_tick = 1'b1; gap(1);
    sec_tick = 1'b1; gap(1);
    check("no_early_match", 32'(state_dbg), 32'd1);
    set_cur(7, 30, 0); sec_tick = 1'b1; cyc();
    check("match_ring", 32'(state_dbg), 32'd2);
    check("match_buzz", 32'(buzzer), 32'd1);

    // blink: visible for ticks 1..30, hidden for 31..60
    for (int k = 1; k <= 60; k++) begin
      gap($urandom_range(0, 3));
      frame_tick = 1'b1; text_pixel_on = 1'b1;
      cyc();
      check("blink", 32'(overlay_on), 32'(k <= 30));
    end

    // snooze and countdown back to ringing
    snooze_btn = 1'b1; cyc();
    check("snooze_state", 32'(state_dbg), 32'd3);
    check("snooze_buzz", 32'(buzzer), 32'd0);
    for (int s = 1; s <= 3; s++) begin
      set_cur(7, 30, s); sec_tick = 1'b1; cyc();
      check("snooze_count", 32'(state_dbg), (s == 3) ? 32'd2 : 32'd3);
      gap(2);
    end
    frame_tick = 1'b1; text_pixel_on = 1'b1; cyc();
    check("resume_phase", 32'(overlay_on), 32'd1);

    // stop beats snooze
    snooze_btn = 1'b1; stop_btn = 1'b1; cyc();
    check("prio_state", 32'(state_dbg), 32'd1);
    check("prio_buzz", 32'(buzzer), 32'd0);

    // alarm_en drop while ringing
    alm_mm = 6'd31; set_cur(7, 31, 0); sec_tick = 1'b1; cyc();
    check("rering", 32'(state_dbg), 32'd2);
    frame_tick = 1'b1; gap(3);
    alarm_en = 1'b0; text_pixel_on = 1'b1; cyc();
    check("drop_state", 32'(state_dbg), 32'd0);
    check("drop_buzz", 32'(buzzer), 32'd0);
    check("drop_show", 32'(overlay_on), 32'd0);

    // ring timeout after RF frames, no retrigger while seconds stay at :00
    alarm_en = 1'b1; cyc();
    alm_hh = 5'd9; alm_mm = 6'd0; set_cur(8, 59, 59); sec_tick = 1'b1; cyc();
    set_cur(9, 0, 0); sec_tick = 1'b1; cyc();
    check("to_ring", 32'(state_dbg), 32'd2);
    for (int k = 1; k <= RF; k++) begin
      gap($urandom_range(0, 2));
      frame_tick = 1'b1; cyc();
      if (k == RF - 1) check("to_before", 32'(state_dbg), 32'd2);
    end
    check("to_armed", 32'(state_dbg), 32'd1);
    check("to_buzz", 32'(buzzer), 32'd0);
    for (int k = 0; k < 3; k++) begin
      sec_tick = 1'b1; cyc(); gap(1);
    end
    check("no_retrigger", 32'(state_dbg), 32'd1);

    // horizontal position while ringing and after stop
`ifdef ALARM_BOUNCE_EN
    xs = '{511, 512, 512, 511, 510, 509};
`else
    xs = '{TX, TX, TX, TX, TX, TX};
`endif
    set_cur(9, 0, 1); cyc();
    alm_hh = 5'd10; set_cur(10, 0, 0); sec_tick = 1'b1; cyc();
    for (int k = 0; k < 6; k++) begin
      gap(1);
      frame_tick = 1'b1; cyc();
      check("bounce_x", 32'(text_x), 32'(xs[k]));
    end
    stop_btn = 1'b1; cyc();
    check("stop_x_hold", 32'(text_x), 32'(xs[5]));
    frame_tick = 1'b1; cyc();
    check("home_x", 32'(text_x), 32'(TX));

    // randomized traffic against the model
    alm_hh = 5'd12; alm_mm = 6'd34;
    for (int i = 0; i < 4000; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      sec_tick   = ($urandom_range(0, 7) == 0);
      snooze_btn = ($urandom_range(0, 59) == 0);
      stop_btn   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
      reset_n = ($urandom_range(0, 999) != 0);
      cur_hh = $urandom_range(0, 1) ? alm_hh : 5'($urandom_range(0, 23));
      cur_mm = $urandom_range(0, 1) ? alm_mm : 6'($urandom_range(0, 59));
      cur_ss = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      text_pixel_on = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
